// File: rtl/vga_sync_module.sv
// vga_sync_module
//   Video timing generator (default 1280x720@60, 74.25 MHz pixel clock).
//   Produces sync pulses, the active-video flag with 0-based pixel
//   addresses, a pixel FIFO pop request leading the picture window by one
//   cycle, and a one-cycle frame-start pulse.
//
// Ports
//   CLK             in   pixel clock
//   RSTn            in   asynchronous active-low reset
//   HSYNC_Sig       out  horizontal sync (polarity set by SYNC_POL)
//   VSYNC_Sig       out  vertical sync (polarity set by SYNC_POL)
//   Ready_Sig       out  high inside the visible area
//   Column_Addr_Sig out  [10:0] visible column, 0 outside visible area
//   Row_Addr_Sig    out  [10:0] visible row, 0 outside visible area
//   pic_rd_req      out  pixel FIFO pop, one cycle ahead of picture window
//   frame_start     out  one-cycle pulse on the first cycle of each frame
//
// All outputs are flops decoded from the previous cycle's counter values.
// H/V totals must fit in 11 bits.
module vga_sync_module #(
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FRONT  = 5,
  parameter int unsigned PIC_W    = 1024,
  parameter int unsigned PIC_H    = 720,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  output logic        HSYNC_Sig,
  output logic        VSYNC_Sig,
  output logic        Ready_Sig,
  output logic [10:0] Column_Addr_Sig,
  output logic [10:0] Row_Addr_Sig,
  output logic        pic_rd_req,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned HS      = H_SYNC + H_BACK;
  localparam int unsigned VS      = V_SYNC + V_BACK;
  // Picture window clipped to the visible area.
  localparam int unsigned PW      = (PIC_W < H_ACTIVE) ? PIC_W : H_ACTIVE;
  localparam int unsigned PH      = (PIC_H < V_ACTIVE) ? PIC_H : V_ACTIVE;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HSYN_E  = 11'(H_SYNC);
  localparam logic [10:0] VSYN_E  = 11'(V_SYNC);
  localparam logic [10:0] HS_C    = 11'(HS);
  localparam logic [10:0] VS_C    = 11'(VS);
  localparam logic [10:0] HE_C    = 11'(HS + H_ACTIVE);
  localparam logic [10:0] VE_C    = 11'(VS + V_ACTIVE);
  localparam logic [10:0] PHE_C   = 11'(HS + PW);
  localparam logic [10:0] PVE_C   = 11'(VS + PH);

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        ready_q, ready_d;
  logic [10:0] col_q, col_d;
  logic [10:0] row_q, row_d;
  logic        req_q, req_d;
  logic        fs_q, fs_d;

  // Counter next-state: v advances (and wraps) only when h wraps.
  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
      end else begin
        v_d = v_q + 11'd1;
      end
    end
  end

  always_comb begin
    hsync_d = (h_q < HSYN_E) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_q < VSYN_E) ? SYNC_POL : ~SYNC_POL;
    ready_d = (h_q >= HS_C) && (h_q < HE_C) && (v_q >= VS_C) && (v_q < VE_C);
    col_d   = '0;
    row_d   = '0;
    if (ready_d) begin
      col_d = h_q - HS_C;
      row_d = v_q - VS_C;
    end
    // Decoded from the next counter value so the request lands one cycle
    // ahead of the pixel, including across line and frame wraps.
    req_d   = (h_d >= HS_C) && (h_d < PHE_C) && (v_d >= VS_C) && (v_d < PVE_C);
    fs_d    = (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      ready_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      req_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ready_q <= ready_d;
      col_q   <= col_d;
      row_q   <= row_d;
      req_q   <= req_d;
      fs_q    <= fs_d;
    end
  end

  assign HSYNC_Sig       = hsync_q;
  assign VSYNC_Sig       = vsync_q;
  assign Ready_Sig       = ready_q;
  assign Column_Addr_Sig = col_q;
  assign Row_Addr_Sig    = row_q;
  assign pic_rd_req      = req_q;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// Bench for vga_sync_module: a default-parameter instance and a small
// inverted-polarity instance, both checked cycle by cycle against an
// arithmetic model of the frame (output cycle k -> position k mod frame).
module tb_vga_sync_module;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic [10:0] col;
    logic [10:0] row;
    logic        req;
    logic        fs;
  } exp_t;

  typedef struct packed {
    exp_t d;
    exp_t s;
  } pair_t;

  logic clk = 1'b0;
  logic rstn_d = 1'b1;
  logic rstn_s = 1'b1;

  logic        hs_d, vs_d, rdy_d, req_d, fs_d;
  logic [10:0] col_d, row_d;
  logic        hs_s, vs_s, rdy_s, req_s, fs_s;
  logic [10:0] col_s, row_s;

  pair_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    done  = 1'b0;

  always #5 clk = ~clk;

  vga_sync_module u_def (
    .CLK(clk), .RSTn(rstn_d),
    .HSYNC_Sig(hs_d), .VSYNC_Sig(vs_d), .Ready_Sig(rdy_d),
    .Column_Addr_Sig(col_d), .Row_Addr_Sig(row_d),
    .pic_rd_req(req_d), .frame_start(fs_d)
  );

  vga_sync_module #(
    .H_SYNC(1), .H_BACK(1), .H_ACTIVE(4), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .PIC_W(3), .PIC_H(5), .SYNC_POL(1'b0)
  ) u_small (
    .CLK(clk), .RSTn(rstn_s),
    .HSYNC_Sig(hs_s), .VSYNC_Sig(vs_s), .Ready_Sig(rdy_s),
    .Column_Addr_Sig(col_s), .Row_Addr_Sig(row_s),
    .pic_rd_req(req_s), .frame_start(fs_s)
  );

  function automatic exp_t rst_val(input bit pol);
    exp_t e;
    e     = '0;
    e.hs  = ~pol;
    e.vs  = ~pol;
    return e;
  endfunction

  // Expected outputs for output cycle k after reset release.
  function automatic exp_t model(input int k,
                                 input int hsy, input int hbk, input int hac, input int hfr,
                                 input int vsy, input int vbk, input int vac, input int vfr,
                                 input int pw, input int ph, input bit pol);
    exp_t e;
    int ht, vt, ft, p, h, v, c, r, nc, nr;
    ht = hsy + hbk + hac + hfr;
    vt = vsy + vbk + vac + vfr;
    ft = ht * vt;
    p  = k % ft;
    h  = p % ht;
    v  = p / ht;
    c  = h - (hsy + hbk);
    r  = v - (vsy + vbk);
    e      = '0;
    e.hs   = (h < hsy) ? pol : ~pol;
    e.vs   = (v < vsy) ? pol : ~pol;
    e.rdy  = (c >= 0) && (c < hac) && (r >= 0) && (r < vac);
    e.col  = e.rdy ? 11'(c) : 11'd0;
    e.row  = e.rdy ? 11'(r) : 11'd0;
    e.fs   = (p == 0);
    p  = (k + 1) % ft;
    nc = (p % ht) - (hsy + hbk);
    nr = (p / ht) - (vsy + vbk);
    e.req  = (nc >= 0) && (nc < hac) && (nc < pw) && (nr >= 0) && (nr < vac) && (nr < ph);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle, samples on the falling edge.
  initial begin
    pair_t x;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("def_hsync", int'(hs_d),  int'(x.d.hs));
        chk("def_vsync", int'(vs_d),  int'(x.d.vs));
        chk("def_ready", int'(rdy_d), int'(x.d.rdy));
        chk("def_col",   int'(col_d), int'(x.d.col));
        chk("def_row",   int'(row_d), int'(x.d.row));
        chk("def_req",   int'(req_d), int'(x.d.req));
        chk("def_fs",    int'(fs_d),  int'(x.d.fs));
        chk("sm_hsync",  int'(hs_s),  int'(x.s.hs));
        chk("sm_vsync",  int'(vs_s),  int'(x.s.vs));
        chk("sm_ready",  int'(rdy_s), int'(x.s.rdy));
        chk("sm_col",    int'(col_s), int'(x.s.col));
        chk("sm_row",    int'(row_s), int'(x.s.row));
        chk("sm_req",    int'(req_s), int'(x.s.req));
        chk("sm_fs",     int'(fs_s),  int'(x.s.fs));
      end
    end
  end

  // Stimulus: reset schedule plus expected-value generation.
  initial begin
    localparam int NCYC  = 62000;
    localparam int MID_K = 10 * 1650 + 700;  // v = 10, h = 700
    pair_t e;
    bit    inrst_d = 1'b1;
    bit    inrst_s = 1'b1;
    bit    mid_done = 1'b0;
    int    k_d = 0;
    int    k_s = 0;
    int    hold_d = 2;
    int    hold_s = 3;

    #2;
    rstn_d = 1'b0;
    rstn_s = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      // default instance
      if (inrst_d) begin
        e.d = rst_val(1'b1);
        if (hold_d == 0) begin
          rstn_d  = 1'b1;
          inrst_d = 1'b0;
          k_d     = 0;
        end else begin
          hold_d--;
        end
      end else if (!mid_done && k_d == MID_K) begin
        rstn_d   = 1'b0;
        inrst_d  = 1'b1;
        mid_done = 1'b1;
        hold_d   = int'($urandom_range(1, 5));
        e.d      = rst_val(1'b1);
      end else begin
        e.d = model(k_d, 40, 220, 1280, 110, 5, 20, 720, 5, 1024, 720, 1'b1);
        k_d++;
      end
      // small instance, random mid-frame resets
      if (inrst_s) begin
        e.s = rst_val(1'b0);
        if (hold_s == 0) begin
          rstn_s  = 1'b1;
          inrst_s = 1'b0;
          k_s     = 0;
        end else begin
          hold_s--;
        end
      end else if ($urandom_range(0, 199) == 0) begin
        rstn_s  = 1'b0;
        inrst_s = 1'b1;
        hold_s  = int'($urandom_range(0, 3));
        e.s     = rst_val(1'b0);
      end else begin
        e.s = model(k_s, 1, 1, 4, 1, 1, 1, 3, 1, 3, 5, 1'b0);
        k_s++;
      end
      q.push_back(e);
    end

    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
